// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// Holds the scanner state encoding, the idle row pattern and small decode helpers.
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2,
        ST_RELEASE  = 2'd3
    } keypad_state_e;

    localparam logic [3:0] KEYS_IDLE               = 4'b1111;
    localparam int         SCAN_DIV_DEFAULT        = 1000;
    localparam int         DEBOUNCE_CYCLES_DEFAULT = 20000;

    // Active-low one-hot column drive for a column index.
    function automatic logic [3:0] col_decode(input logic [1:0] idx);
        logic [3:0] cols;
        cols      = 4'b1111;
        cols[idx] = 1'b0;
        return cols;
    endfunction

    // True when exactly one row line is pulled low (a clean single-key press).
    function automatic logic single_zero(input logic [3:0] rows);
        logic result;
        case (rows)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: result = 1'b1;
            default:                            result = 1'b0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a bus of independent asynchronous lines.
// Reset value is configurable so idle lines do not look active after reset.
module sync_2ff #(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// Column-scanning 4x4 keypad front end with press/release debouncing.
// Scans columns until a row goes low, debounces it, then holds the column until release.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV        = SCAN_DIV_DEFAULT,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [3:0]    rows_n,
    output logic [3:0]    col_n,
    output logic [1:0]    counter,
    output logic [3:0]    keyboard,
    output logic          key_valid,
    output logic          key_held,
    output keypad_state_e state_dbg
);

    localparam int                  DWELL_W    = $clog2(SCAN_DIV);
    localparam int                  STAB_W     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DWELL_W-1:0]  DWELL_LAST = DWELL_W'(SCAN_DIV - 1);
    localparam logic [STAB_W-1:0]   STAB_DONE  = STAB_W'(DEBOUNCE_CYCLES);

    keypad_state_e        state_q;
    logic [1:0]           counter_q;
    logic [3:0]           col_n_q;
    logic [3:0]           keyboard_q;
    logic                 key_valid_q;
    logic                 key_held_q;
    logic [DWELL_W-1:0]   dwell_q;
    logic [STAB_W-1:0]    stab_q;
    logic [3:0]           cand_q;

    logic [3:0]           rows_s;
    logic                 rows_idle;
    logic [1:0]           counter_inc;
    logic [STAB_W-1:0]    stab_inc;
    logic                 stab_hit;

    sync_2ff #(
        .WIDTH     (4),
        .RESET_VAL (KEYS_IDLE)
    ) u_rows_sync (
        .clk_i (clock),
        .rst_i (reset),
        .d_i   (rows_n),
        .q_o   (rows_s)
    );

    assign rows_idle   = (rows_s == KEYS_IDLE);
    assign counter_inc = counter_q + 2'd1;
    // Saturating increment: the stability count never wraps back into range.
    assign stab_inc    = (stab_q == STAB_DONE) ? stab_q : stab_q + STAB_W'(1);
    assign stab_hit    = (stab_inc == STAB_DONE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_SCAN;
            counter_q   <= 2'd0;
            col_n_q     <= 4'b1110;
            keyboard_q  <= KEYS_IDLE;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
            dwell_q     <= '0;
            stab_q      <= '0;
            cand_q      <= KEYS_IDLE;
        end else begin
            key_valid_q <= 1'b0;
            case (state_q)
                ST_SCAN: begin
                    if (dwell_q == DWELL_LAST) begin
                        dwell_q <= '0;
                        if (rows_idle) begin
                            counter_q <= counter_inc;
                            col_n_q   <= col_decode(counter_inc);
                        end else begin
                            state_q <= ST_DEBOUNCE;
                            cand_q  <= rows_s;
                            stab_q  <= '0;
                        end
                    end else begin
                        dwell_q <= dwell_q + DWELL_W'(1);
                    end
                end

                ST_DEBOUNCE: begin
                    if (rows_s == cand_q) begin
                        stab_q <= stab_inc;
                        if (stab_hit) begin
                            state_q <= ST_HELD;
                            // Multi-key (ghosting) patterns freeze the scan but are never reported.
                            if (single_zero(cand_q)) begin
                                keyboard_q  <= cand_q;
                                key_valid_q <= 1'b1;
                                key_held_q  <= 1'b1;
                            end else begin
                                keyboard_q  <= KEYS_IDLE;
                                key_held_q  <= 1'b0;
                            end
                        end
                    end else begin
                        state_q   <= ST_SCAN;
                        stab_q    <= '0;
                        dwell_q   <= '0;
                        counter_q <= counter_inc;
                        col_n_q   <= col_decode(counter_inc);
                    end
                end

                ST_HELD: begin
                    if (rows_idle) begin
                        state_q <= ST_RELEASE;
                        stab_q  <= '0;
                    end
                end

                ST_RELEASE: begin
                    if (!rows_idle) begin
                        state_q <= ST_HELD;
                        stab_q  <= '0;
                    end else begin
                        stab_q <= stab_inc;
                        if (stab_hit) begin
                            state_q    <= ST_SCAN;
                            stab_q     <= '0;
                            dwell_q    <= '0;
                            counter_q  <= counter_inc;
                            col_n_q    <= col_decode(counter_inc);
                            keyboard_q <= KEYS_IDLE;
                            key_held_q <= 1'b0;
                        end
                    end
                end

                default: begin
                    state_q <= ST_SCAN;
                end
            endcase
        end
    end

    assign col_n     = col_n_q;
    assign counter   = counter_q;
    assign keyboard  = keyboard_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4 and DEBOUNCE_CYCLES=8.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_keypad_scanner;
    import keypad_pkg::*;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [3:0]    rows_n = 4'b1111;
    logic [3:0]    col_n;
    logic [1:0]    counter;
    logic [3:0]    keyboard;
    logic          key_valid;
    logic          key_held;
    keypad_state_e state_dbg;

    int tests_run    = 0;
    int tests_failed = 0;

    keypad_scanner #(
        .SCAN_DIV        (4),
        .DEBOUNCE_CYCLES (8)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .rows_n    (rows_n),
        .col_n     (col_n),
        .counter   (counter),
        .keyboard  (keyboard),
        .key_valid (key_valid),
        .key_held  (key_held),
        .state_dbg (state_dbg)
    );

    always #5 clock = ~clock;

    task automatic test_reset();
        rows_n = 4'b1111;
        #2;
        reset = 1'b1;
        #1;
        tests_run++;
        if (col_n !== 4'b1110 || counter !== 2'd0 || keyboard !== 4'b1111 ||
            key_valid !== 1'b0 || key_held !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state col_n=%b counter=%0d keyboard=%b kv=%b kh=%b required 1110/0/1111/0/0",
                     col_n, counter, keyboard, key_valid, key_held);
        end
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_idle_scan();
        logic [1:0] exp_cnt;
        logic [3:0] exp_col;
        for (int j = 1; j <= 20; j++) begin
            @(negedge clock);
            exp_cnt = 2'((j / 4) % 4);
            exp_col = 4'b1111;
            exp_col[exp_cnt] = 1'b0;
            tests_run++;
            if (counter !== exp_cnt || col_n !== exp_col) begin
                tests_failed++;
                $display("FAIL idle_scan cycle %0d counter=%0d col_n=%b required %0d/%b",
                         j, counter, col_n, exp_cnt, exp_col);
            end
        end
    endtask

    task automatic test_single_key();
        int n;
        int pulses;
        int pulse_at;
        int released_at;
        logic moved;
        n = 0;
        while (counter == 2'd2 && n < 20) begin @(negedge clock); n++; end
        while (counter != 2'd2 && n < 40) begin @(negedge clock); n++; end
        tests_run++;
        if (counter !== 2'd2) begin
            tests_failed++;
            $display("FAIL single_sync counter=%0d required 2", counter);
        end
        rows_n = 4'b1101;
        pulses = 0;
        pulse_at = -1;
        moved = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clock);
            if (key_valid === 1'b1) begin
                pulses++;
                pulse_at = k;
            end
            if (counter !== 2'd2 || col_n !== 4'b1011) moved = 1'b1;
        end
        tests_run++;
        if (pulses != 1 || pulse_at != 12) begin
            tests_failed++;
            $display("FAIL single_pulse pulses=%0d at=%0d required 1 at 12", pulses, pulse_at);
        end
        tests_run++;
        if (moved !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_frozen scan moved=%b required 0", moved);
        end
        tests_run++;
        if (keyboard !== 4'b1101 || key_held !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_held keyboard=%b kh=%b required 1101/1", keyboard, key_held);
        end
        rows_n = 4'b1111;
        released_at = -1;
        for (int m = 1; m <= 30; m++) begin
            @(negedge clock);
            if (key_held !== 1'b1) begin
                released_at = m;
                break;
            end
        end
        tests_run++;
        if (released_at != 11) begin
            tests_failed++;
            $display("FAIL single_release_time key_held fell at %0d required 11", released_at);
        end
        tests_run++;
        if (counter !== 2'd3 || col_n !== 4'b0111 || keyboard !== 4'b1111 || key_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_release_state counter=%0d col_n=%b keyboard=%b kv=%b required 3/0111/1111/0",
                     counter, col_n, keyboard, key_valid);
        end
    endtask

    task automatic test_bounce();
        int pulses;
        int changes;
        logic held_seen;
        logic [1:0] prev;
        pulses = 0;
        held_seen = 1'b0;
        for (int p = 0; p < 12; p++) begin
            rows_n = (p % 2 == 0) ? 4'b1011 : 4'b1111;
            repeat (5) begin
                @(negedge clock);
                if (key_valid === 1'b1) pulses++;
                if (key_held !== 1'b0) held_seen = 1'b1;
            end
        end
        tests_run++;
        if (pulses != 0 || held_seen !== 1'b0) begin
            tests_failed++;
            $display("FAIL bounce_no_key pulses=%0d held_seen=%b required 0/0", pulses, held_seen);
        end
        changes = 0;
        prev = counter;
        for (int k = 0; k < 12; k++) begin
            @(negedge clock);
            if (counter !== prev) changes++;
            prev = counter;
        end
        tests_run++;
        if (changes != 3) begin
            tests_failed++;
            $display("FAIL bounce_resume counter changes=%0d required 3", changes);
        end
    endtask

    task automatic test_multi_key();
        int pulses;
        logic bad;
        logic [1:0] c0;
        logic [1:0] c1;
        rows_n = 4'b1001;
        pulses = 0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clock);
            if (key_valid === 1'b1) pulses++;
        end
        c0 = counter;
        bad = 1'b0;
        for (int k = 17; k <= 40; k++) begin
            @(negedge clock);
            if (key_valid === 1'b1) pulses++;
            if (counter !== c0 || keyboard !== 4'b1111 || key_held !== 1'b0) bad = 1'b1;
        end
        tests_run++;
        if (pulses != 0) begin
            tests_failed++;
            $display("FAIL multi_no_pulse pulses=%0d required 0", pulses);
        end
        tests_run++;
        if (bad !== 1'b0) begin
            tests_failed++;
            $display("FAIL multi_frozen counter=%0d keyboard=%b kh=%b required %0d/1111/0",
                     counter, keyboard, key_held, c0);
        end
        rows_n = 4'b1111;
        repeat (10) @(negedge clock);
        tests_run++;
        if (counter !== c0 || state_dbg !== ST_RELEASE) begin
            tests_failed++;
            $display("FAIL multi_release_wait counter=%0d state=%0d required %0d/%0d",
                     counter, state_dbg, c0, ST_RELEASE);
        end
        @(negedge clock);
        c1 = c0 + 2'd1;
        tests_run++;
        if (counter !== c1 || key_held !== 1'b0 || key_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL multi_release_done counter=%0d kh=%b kv=%b required %0d/0/0",
                     counter, key_held, key_valid, c1);
        end
    endtask

    task automatic test_release_glitch();
        int pulses;
        int waited;
        int released_at;
        rows_n = 4'b0111;
        pulses = 0;
        waited = 0;
        while (key_valid !== 1'b1 && waited < 30) begin @(negedge clock); waited++; end
        tests_run++;
        if (key_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL glitch_press key_valid=%b after %0d cycles required 1", key_valid, waited);
        end else begin
            pulses = 1;
        end
        repeat (5) begin
            @(negedge clock);
            if (key_valid === 1'b1) pulses++;
        end
        rows_n = 4'b1111;
        repeat (5) begin
            @(negedge clock);
            if (key_valid === 1'b1) pulses++;
        end
        rows_n = 4'b0111;
        repeat (3) begin
            @(negedge clock);
            if (key_valid === 1'b1) pulses++;
        end
        rows_n = 4'b1111;
        released_at = -1;
        for (int m = 1; m <= 30; m++) begin
            @(negedge clock);
            if (key_valid === 1'b1) pulses++;
            if (key_held !== 1'b1) begin
                released_at = m;
                break;
            end
        end
        tests_run++;
        if (released_at != 11) begin
            tests_failed++;
            $display("FAIL glitch_rehold key_held fell at %0d required 11", released_at);
        end
        tests_run++;
        if (pulses != 1) begin
            tests_failed++;
            $display("FAIL glitch_single_pulse pulses=%0d required 1", pulses);
        end
    endtask

    task automatic test_reset_mid(input logic wait_for_held);
        int pulses;
        int waited;
        rows_n = 4'b1110;
        waited = 0;
        if (wait_for_held) begin
            while (key_held !== 1'b1 && waited < 30) begin @(negedge clock); waited++; end
            repeat (3) @(negedge clock);
        end else begin
            repeat (8) @(negedge clock);
        end
        tests_run++;
        if ((wait_for_held && key_held !== 1'b1) || (!wait_for_held && state_dbg !== ST_DEBOUNCE)) begin
            tests_failed++;
            $display("FAIL reset_mid_setup held=%b kh=%b state=%0d", wait_for_held, key_held, state_dbg);
        end
        #2;
        reset = 1'b1;
        rows_n = 4'b1111;
        #1;
        tests_run++;
        if (col_n !== 4'b1110 || counter !== 2'd0 || keyboard !== 4'b1111 ||
            key_valid !== 1'b0 || key_held !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_state held=%b col_n=%b counter=%0d keyboard=%b kv=%b kh=%b required 1110/0/1111/0/0",
                     wait_for_held, col_n, counter, keyboard, key_valid, key_held);
        end
        repeat (2) @(negedge clock);
        reset = 1'b0;
        pulses = 0;
        repeat (20) begin
            @(negedge clock);
            if (key_valid === 1'b1 || key_held === 1'b1) pulses++;
        end
        tests_run++;
        if (pulses != 0) begin
            tests_failed++;
            $display("FAIL reset_mid_discard held=%b key activity=%0d cycles required 0", wait_for_held, pulses);
        end
    endtask

    initial begin
        test_reset();
        test_idle_scan();
        test_single_key();
        test_bounce();
        test_multi_key();
        test_release_glitch();
        test_reset_mid(1'b0);
        test_reset_mid(1'b1);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1000, clock cycles each column is driven before the next is selected (min 2).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 20000, consecutive stable cycles required to accept a press or release (min 2).
REQ-003 SHALL have port clock  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port rows_n  input  4  raw keypad row lines, active-low, asynchronous to clock.
REQ-006 SHALL have port col_n  output  4  column drive, active-low one-hot; col_n[i]=0 when counter==i.
REQ-007 SHALL have port counter  output  2  index of the currently driven column, feeding the downstream encoder.
REQ-008 SHALL have port keyboard  output  4  debounced row pattern for the downstream encoder; 4'b1111 when no key is accepted.
REQ-009 SHALL have port key_valid  output  1  single-cycle pulse on acceptance of a single-key press.
REQ-010 SHALL have port key_held  output  1  high from acceptance until release is debounced.

Function
REQ-011 SHALL pass rows_n through a two-flop synchronizer (reset value 4'b1111); rows_s below is its output.
REQ-012 SHALL implement states SCAN, DEBOUNCE, HELD, RELEASE.
REQ-013 In SCAN, a dwell counter SHALL run 0..SCAN_DIV-1. At terminal count: rows_s==4'b1111 -> counter increments (3 wraps to 0), dwell clears. Otherwise -> DEBOUNCE, counter frozen, rows_s captured as cand.
REQ-014 In DEBOUNCE, a stability counter SHALL increment each cycle rows_s==cand. Any mismatch -> SCAN with counter advanced by one.
REQ-015 When stability reaches DEBOUNCE_CYCLES with cand containing exactly one zero, SHALL enter HELD, load keyboard=cand, and pulse key_valid for exactly that one cycle.
REQ-016 When stability reaches DEBOUNCE_CYCLES with cand containing two or more zeros (ghost/multi-key), SHALL enter HELD with keyboard=4'b1111, key_valid=0, key_held=0.
REQ-017 In HELD, counter, col_n and keyboard SHALL stay constant. rows_s==4'b1111 -> RELEASE, stability counter cleared.
REQ-018 In RELEASE, rows_s==4'b1111 SHALL increment the stability counter. Any zero -> back to HELD. Reaching DEBOUNCE_CYCLES -> SCAN: counter advanced, dwell cleared, keyboard=4'b1111, key_held=0.
REQ-019 SHALL never assert key_valid twice for one press, nor during auto-repeat.
REQ-020 Dwell and stability counters SHALL be $clog2-sized to their parameter and SHALL saturate, never wrap.
REQ-021 col_n SHALL be a registered decode of counter, with no cycle in which two columns are low.

Reset
REQ-022 Reset SHALL take effect immediately: state=SCAN, counter=0, col_n=4'b1110, keyboard=4'b1111, key_valid=0, key_held=0, all internal counters=0, synchronizer=4'b1111.
REQ-023 Reset asserted in any state, including mid-DEBOUNCE or HELD, SHALL discard the pending key with no key_valid pulse.

Structure
REQ-024 Package keypad_pkg SHALL hold the state enum, the KEYS_IDLE=4'b1111 constant and the default SCAN_DIV/DEBOUNCE_CYCLES values.
REQ-025 The synchronizer SHALL be a separate sub-module sync_2ff, 4 bits wide; all other logic is flat.

Verification (SCAN_DIV=4, DEBOUNCE_CYCLES=8)
REQ-026 Reset pulse mid-run -> col_n=1110, counter=0, keyboard=1111, key_valid=0, key_held=0 immediately.
REQ-027 rows_n=1111 idle 20 cycles -> counter steps 0,1,2,3,0 every 4 cycles; col_n 1110,1101,1011,0111.
REQ-028 rows_n=1101 during column 2, held 40 cycles -> exactly one key_valid pulse, keyboard=1101, counter stays 2, key_held=1; after release plus 8 stable cycles -> key_held=0, counter=3.
REQ-029 rows_n=1011 toggled every 5 cycles -> no key_valid; scanning resumes.
REQ-030 rows_n=1001 held 40 cycles -> no key_valid, keyboard=1111, scan frozen until release is debounced.
REQ-031 Release glitch (rows back to 0111 for 3 cycles inside RELEASE) -> returns to HELD, no second key_valid.
